tlul_txn_buffer: RTL and testbench

TLUL_TXN_BUFFER -- requirements
Module: tlul_txn_buffer

---
 rtl/tlul_txn_buffer.sv | 91 +++++++++
 tb/tb_tlul_txn_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_txn_buffer.sv
// tlul_txn_buffer: registered TL-UL request/response FIFOs with an in-flight transaction limiter.
module tlul_txn_fifo #(
   parameter int W     = 8,
   parameter int Depth = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(Depth) + 1;
   logic [W-1:0]  mem [Depth];
   logic [PW-1:0] wptr, rptr;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop) rptr <= rptr + PW'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr[PW-2:0]] <= wdata;
   end
   assign rdata = mem[rptr[PW-2:0]];
   // Extra wrap bit distinguishes full from empty when the addresses coincide.
   assign full  = (wptr[PW-2:0] == rptr[PW-2:0]) && (wptr[PW-1] != rptr[PW-1]);
   assign empty = wptr == rptr;
endmodule

module tlul_txn_buffer #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int AIW            = 8,
   parameter int ReqDepth       = 4,
   parameter int RspDepth       = 4,
   parameter int MaxOutstanding = 4,
   localparam int DBW = DW / 8,
   localparam int APW = 3 + AW + DW + DBW + AIW,
   localparam int DPW = 3 + DW + AIW + 1,
   localparam int CW  = $clog2(MaxOutstanding + 1)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           host_a_valid_i,
   output logic           host_a_ready_o,
   input  logic [APW-1:0] host_a_pl_i,
   output logic           dev_a_valid_o,
   input  logic           dev_a_ready_i,
   output logic [APW-1:0] dev_a_pl_o,
   input  logic           dev_d_valid_i,
   output logic           dev_d_ready_o,
   input  logic [DPW-1:0] dev_d_pl_i,
   output logic           host_d_valid_o,
   input  logic           host_d_ready_i,
   output logic [DPW-1:0] host_d_pl_o,
   output logic [CW-1:0]  outstanding_o,
   output logic           limit_hit_o
);
   logic a_full, a_empty, d_full, d_empty, a_push, a_pop, d_push, d_pop;
   logic [CW-1:0] cnt;
   assign host_a_ready_o = !a_full;
   assign dev_a_valid_o  = !a_empty && (cnt < CW'(MaxOutstanding));
   assign dev_d_ready_o  = !d_full;
   assign host_d_valid_o = !d_empty;
   assign a_push = host_a_valid_i && host_a_ready_o;
   assign a_pop  = dev_a_valid_o && dev_a_ready_i;
   assign d_push = dev_d_valid_i && dev_d_ready_o;
   assign d_pop  = host_d_valid_o && host_d_ready_i;
   tlul_txn_fifo #(.W(APW), .Depth(ReqDepth)) u_a_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push(a_push), .pop(a_pop),
      .wdata(host_a_pl_i), .rdata(dev_a_pl_o), .full(a_full), .empty(a_empty)
   );
   tlul_txn_fifo #(.W(DPW), .Depth(RspDepth)) u_d_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push(d_push), .pop(d_pop),
      .wdata(dev_d_pl_i), .rdata(host_d_pl_o), .full(d_full), .empty(d_empty)
   );
   // A response arriving with nothing in flight must not wrap the counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt <= '0;
      else if (a_pop && !d_pop) cnt <= cnt + CW'(1);
      else if (d_pop && !a_pop && cnt != '0) cnt <= cnt - CW'(1);
   end
   assign outstanding_o = cnt;
   assign limit_hit_o   = cnt == CW'(MaxOutstanding);
endmodule

// File: tb/tb_tlul_txn_buffer.sv
// tb_tlul_txn_buffer: scoreboard bench for tlul_txn_buffer (default limit 4, plus a limit-2 instance).
module tb_tlul_txn_buffer;
   localparam int APW = 3 + 32 + 32 + 4 + 8;
   localparam int DPW = 3 + 32 + 8 + 1;
   logic clk = 0, rst_n = 1;
   logic host_a_valid = 0, dev_a_ready = 0, dev_d_valid = 0, host_d_ready = 0;
   logic host_a_ready, dev_a_valid, dev_d_ready, host_d_valid, limit_hit;
   logic [APW-1:0] host_a_pl = '0, dev_a_pl;
   logic [DPW-1:0] dev_d_pl = '0, host_d_pl;
   logic [2:0] outstanding;
   logic m_a_valid = 0, m_dev_a_ready = 0, m_dev_d_valid = 0, m_host_d_ready = 0;
   logic m_a_ready, m_dev_a_valid, m_dev_d_ready, m_host_d_valid, m_limit;
   logic [APW-1:0] m_a_pl = '0, m_dev_a_pl;
   logic [DPW-1:0] m_dev_d_pl = '0, m_host_d_pl;
   logic [1:0] m_out;
   int vectors = 0, miscompares = 0, last_n = 0;
   logic [APW-1:0] exp_a[$];
   logic [DPW-1:0] exp_d[$];

   always #5 clk = ~clk;

   tlul_txn_buffer dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_a_valid_i(host_a_valid), .host_a_ready_o(host_a_ready), .host_a_pl_i(host_a_pl),
      .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready), .dev_a_pl_o(dev_a_pl),
      .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready), .dev_d_pl_i(dev_d_pl),
      .host_d_valid_o(host_d_valid), .host_d_ready_i(host_d_ready), .host_d_pl_o(host_d_pl),
      .outstanding_o(outstanding), .limit_hit_o(limit_hit)
   );

   tlul_txn_buffer #(.MaxOutstanding(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .host_a_valid_i(m_a_valid), .host_a_ready_o(m_a_ready), .host_a_pl_i(m_a_pl),
      .dev_a_valid_o(m_dev_a_valid), .dev_a_ready_i(m_dev_a_ready), .dev_a_pl_o(m_dev_a_pl),
      .dev_d_valid_i(m_dev_d_valid), .dev_d_ready_o(m_dev_d_ready), .dev_d_pl_i(m_dev_d_pl),
      .host_d_valid_o(m_host_d_valid), .host_d_ready_i(m_host_d_ready), .host_d_pl_o(m_host_d_pl),
      .outstanding_o(m_out), .limit_hit_o(m_limit)
   );

   function automatic logic [APW-1:0] mk_a(input logic [7:0] src, input logic [31:0] d);
      return {3'd4, 32'h4000_0000 | {24'h0, src}, d, 4'hf, src};
   endfunction

   function automatic logic [DPW-1:0] mk_d(input logic [7:0] src, input logic [31:0] d);
      return {3'd1, d, src, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [APW-1:0] pl);
      int n = 0;
      logic hs = 0;
      host_a_valid = 1;
      host_a_pl = pl;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = host_a_ready;
         @(posedge clk);
         #1;
         n++;
      end
      host_a_valid = 0;
      last_n = n;
      if (hs) exp_a.push_back(pl);
      else begin
         vectors++;
         miscompares++;
         $display("FAIL push_a timeout: got no ready want ready");
      end
   endtask

   task automatic push_d(input logic [DPW-1:0] pl);
      int n = 0;
      logic hs = 0;
      dev_d_valid = 1;
      dev_d_pl = pl;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = dev_d_ready;
         @(posedge clk);
         #1;
         n++;
      end
      dev_d_valid = 0;
      if (hs) exp_d.push_back(pl);
      else begin
         vectors++;
         miscompares++;
         $display("FAIL push_d timeout: got no ready want ready");
      end
   endtask

   task automatic drain();
      int n = 0;
      dev_a_ready = 1;
      host_d_ready = 1;
      while ((exp_a.size() != 0 || outstanding != 0) && n < 200) begin
         if (outstanding != 0) push_d(mk_d(8'hd0, n));
         else cyc();
         n++;
      end
      cyc(6);
      chk("drain_exp_a", exp_a.size(), 0);
      chk("drain_exp_d", exp_d.size(), 0);
      chk("drain_outstanding", outstanding, 0);
   endtask

   // Monitor: every handshake on an output channel is compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && dev_a_valid && dev_a_ready) begin
         if (exp_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dev_a spurious: got %0h want nothing", dev_a_pl);
         end else chk("dev_a_pl", dev_a_pl, exp_a.pop_front());
      end
      if (rst_n && host_d_valid && host_d_ready) begin
         if (exp_d.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL host_d spurious: got %0h want nothing", host_d_pl);
         end else chk("host_d_pl", host_d_pl, exp_d.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #1 rst_n = 0;
      #1;
      chk("rst_host_a_ready", host_a_ready, 1);
      chk("rst_dev_d_ready", dev_d_ready, 1);
      chk("rst_dev_a_valid", dev_a_valid, 0);
      chk("rst_host_d_valid", host_d_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_limit_hit", limit_hit, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      // four requests to the limit, first accepted on the first edge after release
      dev_a_ready = 1;
      host_d_ready = 1;
      push_a(mk_a(8'h01, 32'hA001));
      chk("first_accept_cycles", last_n, 1);
      chk("latency_dev_a_valid", dev_a_valid, 1);
      for (int i = 2; i <= 4; i++) push_a(mk_a(8'(i), 32'hA000 + i));
      cyc(2);
      chk("limit_outstanding", outstanding, 4);
      chk("limit_hit", limit_hit, 1);
      dev_a_ready = 0;
      push_a(mk_a(8'h05, 32'hA005));
      cyc();
      chk("limit_gates_dev_a", dev_a_valid, 0);
      chk("limit_outstanding_held", outstanding, 4);
      push_d(mk_d(8'h01, 32'hD001));
      cyc();
      chk("after_rsp_outstanding", outstanding, 3);
      chk("after_rsp_dev_a_valid", dev_a_valid, 1);
      chk("after_rsp_limit_hit", limit_hit, 0);
      // request issue and response retire in the same cycle
      host_d_ready = 0;
      push_d(mk_d(8'h02, 32'hD002));
      chk("pending_host_d_valid", host_d_valid, 1);
      dev_a_ready = 1;
      host_d_ready = 1;
      cyc();
      dev_a_ready = 0;
      host_d_ready = 0;
      chk("simul_outstanding", outstanding, 3);
      drain();
      // A FIFO full with a refused push during a simultaneous pop
      dev_a_ready = 0;
      for (int i = 0; i < 4; i++) push_a(mk_a(8'h10 + 8'(i), 32'hB000 + i));
      chk("full_host_a_ready", host_a_ready, 0);
      host_a_valid = 1;
      host_a_pl = mk_a(8'h14, 32'hB004);
      cyc(2);
      chk("full_held_host_a_ready", host_a_ready, 0);
      dev_a_ready = 1;
      cyc();
      dev_a_ready = 0;
      chk("no_pushthrough_ready", host_a_ready, 1);
      cyc();
      host_a_valid = 0;
      exp_a.push_back(mk_a(8'h14, 32'hB004));
      chk("refill_full", host_a_ready, 0);
      drain();
      // ten push/pop pairs wrap both FIFOs' pointers twice
      for (int i = 0; i < 10; i++) begin
         push_a(mk_a(8'h20 + 8'(i), 32'(i)));
         cyc();
         chk("wrap_dev_a_empty", dev_a_valid, 0);
         chk("wrap_host_a_ready", host_a_ready, 1);
         push_d(mk_d(8'h20 + 8'(i), 32'(i)));
         cyc();
         chk("wrap_outstanding", outstanding, 0);
         chk("wrap_host_d_empty", host_d_valid, 0);
      end
      // response with nothing in flight
      push_d(mk_d(8'h77, 32'h77));
      cyc(2);
      chk("no_underflow", outstanding, 0);
      // asynchronous reset with three entries in each FIFO and three in flight
      dev_a_ready = 1;
      for (int i = 0; i < 3; i++) push_a(mk_a(8'h40 + 8'(i), 32'hC000 + i));
      cyc();
      dev_a_ready = 0;
      for (int i = 3; i < 6; i++) push_a(mk_a(8'h40 + 8'(i), 32'hC000 + i));
      host_d_ready = 0;
      for (int i = 0; i < 3; i++) push_d(mk_d(8'h40 + 8'(i), 32'hE000 + i));
      chk("pre_rst_outstanding", outstanding, 3);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      exp_a.delete();
      exp_d.delete();
      chk("mid_rst_host_a_ready", host_a_ready, 1);
      chk("mid_rst_dev_d_ready", dev_d_ready, 1);
      chk("mid_rst_dev_a_valid", dev_a_valid, 0);
      chk("mid_rst_host_d_valid", host_d_valid, 0);
      chk("mid_rst_outstanding", outstanding, 0);
      chk("mid_rst_limit_hit", limit_hit, 0);
      dev_a_ready = 1;
      host_d_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      push_a(mk_a(8'h50, 32'hF050));
      chk("post_rst_accept_cycles", last_n, 1);
      cyc(3);
      chk("post_rst_outstanding", outstanding, 1);
      chk("post_rst_host_d_valid", host_d_valid, 0);
      drain();
      // limit-2 instance: third request waits until one response retires
      m_dev_a_ready = 1;
      m_host_d_ready = 1;
      m_a_valid = 1;
      for (int i = 0; i < 3; i++) begin
         m_a_pl = mk_a(8'h31 + 8'(i), 32'(i));
         cyc();
      end
      m_a_valid = 0;
      cyc(3);
      chk("m_outstanding", m_out, 2);
      chk("m_limit_hit", m_limit, 1);
      chk("m_dev_a_blocked", m_dev_a_valid, 0);
      chk("m_waiting_pl", m_dev_a_pl, mk_a(8'h33, 32'd2));
      m_dev_d_valid = 1;
      m_dev_d_pl = mk_d(8'h31, 32'h0);
      cyc();
      m_dev_d_valid = 0;
      cyc();
      chk("m_after_rsp_outstanding", m_out, 1);
      chk("m_after_rsp_dev_a_valid", m_dev_a_valid, 1);
      cyc();
      chk("m_third_issued_outstanding", m_out, 2);
      chk("m_third_issued_dev_a_valid", m_dev_a_valid, 0);
      chk("end_exp_a", exp_a.size(), 0);
      chk("end_exp_d", exp_d.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
